// File: rtl/imem_arbiter.sv
// Instruction memory arbiter: fetch vs debug/loader, with halt handshake.
// Optional grant counters (f_cnt/d_cnt/clr_cnt) when IMEM_ARB_STATS_EN is defined.
module imem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              d_halt_req,
  output logic              d_halt_ack,
`ifdef IMEM_ARB_STATS_EN
  output logic [15:0]       f_cnt,
  output logic [15:0]       d_cnt,
  input  logic              clr_cnt,
`endif
  output logic              mem_cs_n,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  localparam logic [3:0] WMAX = 4'(MAX_WAIT);

  state_t            state;
  state_t            state_nx;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              f_vld_q;
  logic              f_err_q;
  logic [DATA_W-1:0] f_rdata_q;
  logic              d_vld_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              d_pri;
  logic              f_mis;
  logic              f_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:     if (d_halt_req) state_nx = DRAIN;
      DRAIN:   state_nx = d_halt_req ? HALTED : RUN;
      HALTED:  if (!d_halt_req) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  // Grants are forced low while reset is asserted so memory is idle at once.
  always_comb begin
    d_pri = (wait_cnt == WMAX);
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst) begin
      unique case (state)
        RUN: begin
          d_gnt = d_req && (d_pri || !f_req);
          f_gnt = f_req && !d_gnt;
        end
        DRAIN, HALTED: d_gnt = d_req;
        default: ;
      endcase
    end
  end

  assign f_mis      = (f_addr[1:0] != 2'b00);
  assign f_acc      = f_gnt && !f_mis;
  assign mem_cs_n   = !(f_acc || d_gnt);
  assign mem_addr   = d_gnt ? d_addr : (f_acc ? f_addr : addr_q);
  assign f_rvalid   = f_vld_q && !f_flush;
  assign f_err      = f_err_q && !f_flush;
  assign f_rdata    = f_rdata_q;
  assign d_rvalid   = d_vld_q;
  assign d_rdata    = d_rdata_q;
  assign d_halt_ack = (state == HALTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      wait_cnt  <= '0;
      f_vld_q   <= 1'b0;
      f_err_q   <= 1'b0;
      f_rdata_q <= '0;
      d_vld_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      f_vld_q <= f_gnt;
      f_err_q <= f_gnt && f_mis;
      d_vld_q <= d_gnt;
      if (!mem_cs_n) addr_q <= mem_addr;
      if (f_gnt) f_rdata_q <= f_mis ? '0 : mem_rdata;
      if (d_gnt) d_rdata_q <= mem_rdata;
      if (d_gnt)
        wait_cnt <= '0;
      else if (d_req && wait_cnt != WMAX)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

`ifdef IMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_cnt <= '0;
      d_cnt <= '0;
    end else if (clr_cnt) begin
      f_cnt <= '0;
      d_cnt <= '0;
    end else begin
      if (f_gnt) f_cnt <= f_cnt + 16'd1;
      if (d_gnt) d_cnt <= d_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: vector table with response scoreboard,
// plus a hand-written reset-during-access sequence.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, f_flush, d_req, d_halt_req;
  logic [31:0] f_addr, d_addr;
  logic        f_gnt, f_rvalid, f_err;
  logic [31:0] f_rdata;
  logic        d_gnt, d_rvalid, d_halt_ack;
  logic [31:0] d_rdata;
  logic        mem_cs_n;
  logic [31:0] mem_addr, mem_rdata;
`ifdef IMEM_ARB_STATS_EN
  logic [15:0] f_cnt, d_cnt;
  logic        clr_cnt = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  assign mem_rdata = mem_f(mem_addr);

  imem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
    .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_halt_req(d_halt_req), .d_halt_ack(d_halt_ack),
`ifdef IMEM_ARB_STATS_EN
    .f_cnt(f_cnt), .d_cnt(d_cnt), .clr_cnt(clr_cnt),
`endif
    .mem_cs_n(mem_cs_n), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        fr;
    logic [31:0] fa;
    logic        fl;
    logic        dr;
    logic [31:0] da;
    logic        h;
    logic        efg;
    logic        edg;
    logic        eack;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } resp_t;

  vec_t        tv[$];
  resp_t       fq[$];
  resp_t       dq[$];
  logic [31:0] last_addr = 32'h0;
  logic        addr_known = 1'b1;

  task automatic add(input logic fr, input logic [31:0] fa, input logic fl,
                     input logic dr, input logic [31:0] da, input logic h,
                     input logic efg, input logic edg, input logic eack);
    vec_t v;
    v.fr = fr; v.fa = fa; v.fl = fl; v.dr = dr; v.da = da; v.h = h;
    v.efg = efg; v.edg = edg; v.eack = eack;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    resp_t r;
    logic  mis;
    logic  acc;
    @(posedge clk);
    #1;
    f_req = v.fr; f_addr = v.fa; f_flush = v.fl;
    d_req = v.dr; d_addr = v.da; d_halt_req = v.h;
    @(negedge clk);
    chk("f_gnt", idx, 32'(f_gnt), 32'(v.efg));
    chk("d_gnt", idx, 32'(d_gnt), 32'(v.edg));
    chk("d_halt_ack", idx, 32'(d_halt_ack), 32'(v.eack));
    if (fq.size() > 0) begin
      r = fq.pop_front();
      if (v.fl) begin
        chk("f_rvalid_flushed", idx, 32'(f_rvalid), 32'd0);
        chk("f_err_flushed", idx, 32'(f_err), 32'd0);
      end else begin
        chk("f_rvalid", idx, 32'(f_rvalid), 32'd1);
        chk("f_err", idx, 32'(f_err), 32'(r.err));
        chk("f_rdata", idx, f_rdata, r.data);
      end
    end else begin
      chk("f_rvalid_idle", idx, 32'(f_rvalid), 32'd0);
    end
    if (dq.size() > 0) begin
      r = dq.pop_front();
      chk("d_rvalid", idx, 32'(d_rvalid), 32'd1);
      chk("d_rdata", idx, d_rdata, r.data);
    end else begin
      chk("d_rvalid_idle", idx, 32'(d_rvalid), 32'd0);
    end
    mis = (v.fa[1:0] != 2'b00);
    acc = (v.efg && !mis) || v.edg;
    chk("mem_cs_n", idx, 32'(mem_cs_n), 32'(!acc));
    if (v.edg) begin
      chk("mem_addr_d", idx, mem_addr, v.da);
      last_addr = v.da; addr_known = 1'b1;
    end else if (acc) begin
      chk("mem_addr_f", idx, mem_addr, v.fa);
      last_addr = v.fa; addr_known = 1'b1;
    end else if (v.efg) begin
      addr_known = 1'b0;
    end else if (addr_known) begin
      chk("mem_addr_hold", idx, mem_addr, last_addr);
    end
    if (v.efg) begin
      r.err = mis; r.data = mis ? 32'h0 : mem_f(v.fa);
      fq.push_back(r);
    end
    if (v.edg) begin
      r.err = 1'b0; r.data = mem_f(v.da);
      dq.push_back(r);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    f_req = 0; f_addr = 0; f_flush = 0;
    d_req = 0; d_addr = 0; d_halt_req = 0;

    //  fr  fa         fl dr da         h  fg dg ack
    add(1, 32'h00,     0, 0, 32'h0,     0, 1, 0, 0);
    add(1, 32'h04,     0, 0, 32'h0,     0, 1, 0, 0);
    add(1, 32'h08,     0, 0, 32'h0,     0, 1, 0, 0);
    add(0, 32'h00,     0, 0, 32'h0,     0, 0, 0, 0);
    add(1, 32'h0C,     0, 1, 32'h40,    0, 1, 0, 0);
    add(1, 32'h10,     0, 1, 32'h40,    0, 1, 0, 0);
    add(1, 32'h14,     0, 1, 32'h40,    0, 1, 0, 0);
    add(1, 32'h18,     0, 1, 32'h40,    0, 1, 0, 0);
    add(1, 32'h1C,     0, 1, 32'h40,    0, 0, 1, 0);
    add(1, 32'h1C,     0, 1, 32'h44,    0, 1, 0, 0);
    add(1, 32'h20,     0, 1, 32'h44,    0, 1, 0, 0);
    add(1, 32'h24,     0, 1, 32'h44,    0, 1, 0, 0);
    add(1, 32'h28,     0, 1, 32'h44,    0, 1, 0, 0);
    add(1, 32'h2C,     0, 1, 32'h44,    0, 0, 1, 0);
    add(1, 32'h2C,     0, 0, 32'h0,     0, 1, 0, 0);
    add(1, 32'h06,     0, 0, 32'h0,     0, 1, 0, 0);
    add(0, 32'h00,     0, 0, 32'h0,     0, 0, 0, 0);
    add(1, 32'h10,     0, 0, 32'h0,     0, 1, 0, 0);
    add(1, 32'h20,     1, 0, 32'h0,     0, 1, 0, 0);
    add(0, 32'h00,     0, 0, 32'h0,     0, 0, 0, 0);
    add(1, 32'h30,     0, 0, 32'h0,     1, 1, 0, 0);
    add(1, 32'h34,     0, 0, 32'h0,     1, 0, 0, 0);
    add(1, 32'h34,     0, 1, 32'h100,   1, 0, 1, 1);
    add(1, 32'h34,     0, 0, 32'h0,     1, 0, 0, 1);
    add(1, 32'h34,     0, 0, 32'h0,     0, 0, 0, 1);
    add(1, 32'h34,     0, 0, 32'h0,     0, 1, 0, 0);
    add(0, 32'h00,     0, 0, 32'h0,     1, 0, 0, 0);
    add(1, 32'h38,     0, 0, 32'h0,     0, 0, 0, 0);
    add(1, 32'h38,     0, 0, 32'h0,     0, 1, 0, 0);
    add(0, 32'h00,     0, 1, 32'h200,   0, 0, 1, 0);
    add(0, 32'h00,     0, 1, 32'h202,   0, 0, 1, 0);
    add(0, 32'h00,     0, 0, 32'h0,     0, 0, 0, 0);

    #12;
    chk("rst_f_rvalid", 0, 32'(f_rvalid), 32'd0);
    chk("rst_f_err", 0, 32'(f_err), 32'd0);
    chk("rst_f_rdata", 0, f_rdata, 32'h0);
    chk("rst_d_rvalid", 0, 32'(d_rvalid), 32'd0);
    chk("rst_d_rdata", 0, d_rdata, 32'h0);
    chk("rst_ack", 0, 32'(d_halt_ack), 32'd0);
    chk("rst_cs_n", 0, 32'(mem_cs_n), 32'd1);
    chk("rst_mem_addr", 0, mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tv.size(); i++) step(tv[i], i + 1);

    // Reset asserted while a fetch grant is outstanding.
    @(posedge clk);
    #1;
    f_req = 1'b1; f_addr = 32'h50; d_req = 1'b0; d_halt_req = 1'b0;
    f_flush = 1'b0;
    @(negedge clk);
    chk("pre_rst_f_gnt", 100, 32'(f_gnt), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_f_gnt", 100, 32'(f_gnt), 32'd0);
    chk("mid_rst_cs_n", 100, 32'(mem_cs_n), 32'd1);
    chk("mid_rst_mem_addr", 100, mem_addr, 32'h0);
    chk("mid_rst_f_rvalid", 100, 32'(f_rvalid), 32'd0);
    chk("mid_rst_ack", 100, 32'(d_halt_ack), 32'd0);
    f_req = 1'b0;
    @(posedge clk);
    #1;
    chk("in_rst_f_rvalid", 101, 32'(f_rvalid), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_f_rvalid", 102 + i, 32'(f_rvalid), 32'd0);
      chk("post_rst_d_rvalid", 102 + i, 32'(d_rvalid), 32'd0);
      chk("post_rst_cs_n", 102 + i, 32'(mem_cs_n), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
